alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL use the following ports, one clock domain; the reset is asynchronous and active-high.
  clk         in   1   rising-edge clock
  rst         in   1   asynchronous, active-high reset
  in_valid    in   1   decode stage offers an instruction
  in_ready    out  1   block accepts the offered instruction
  instr       in   32  RV32 instruction word
  rs1_data    in   32  register file value for rs1
  rs2_data    in   32  register file value for rs2
  flush       in   1   discard all held and offered instructions
  ex_valid    out  1   ALU operand bundle valid
  ex_ready    in   1   execute stage consumes the bundle
  alu_a       out  32  ALU operand a
  alu_b       out  32  ALU operand b
  alu_op      out  4   ALU operation, alu_pkg encoding
  rd          out  5   destination register
  reg_write   out  1   destination write enable
  illegal     out  1   instruction not decodable by this block
REQ-002 alu_op values SHALL be the alu_pkg enumerators ALU_ADD, ALU_SUB, ALU_SLT and ALU_SLLI.

Function
REQ-003 Input transfer SHALL occur on a rising edge with in_valid && in_ready && !flush. Output transfer SHALL occur with ex_valid && ex_ready.
REQ-004 Decoding SHALL follow these rules:
  - opcode 0110011, funct3 000, funct7 0000000: ALU_ADD, a=rs1_data, b=rs2_data
  - opcode 0110011, funct3 000, funct7 0100000: ALU_SUB, a=rs1_data, b=rs2_data
  - opcode 0110011, funct3 010, funct7 0000000: ALU_SLT, a=rs1_data, b=rs2_data
  - opcode 0010011, funct3 000: ALU_ADD, a=rs1_data, b=sign-extended instr[31:20]
  - opcode 0010011, funct3 010: ALU_SLT, a=rs1_data, b=sign-extended instr[31:20]
  - opcode 0010011, funct3 001, instr[31:25]=0: ALU_SLLI, a=rs1_data, b={27'b0, instr[24:20]}
REQ-005 Any other encoding SHALL produce illegal=1, alu_op=ALU_ADD, alu_a=0, alu_b=0 and reg_write=0, and SHALL still be transferred as a normal entry.
REQ-006 rd SHALL equal instr[11:7]. For legal instructions, reg_write SHALL be 1 exactly when rd != 0.
REQ-007 Decoding SHALL be performed at acceptance, and the decoded bundle SHALL be registered. Latency from input transfer to ex_valid SHALL be one cycle when the block is empty.
REQ-008 Buffering SHALL use a main register that drives the outputs and a one-entry skid register. There SHALL be three states:
  - EMPTY: main register empty
  - HALF: main register full, skid register empty
  - FULL: both registers full
REQ-009 State transitions (in = input transfer, out = output transfer):
  - EMPTY: in -> HALF
  - HALF: in && !out -> FULL; out && !in -> EMPTY; in && out -> HALF, with the main register reloaded
  - FULL: out -> HALF, with the skid register moved to the main register
REQ-010 in_ready SHALL be a registered output equal to (state != FULL). No combinational path SHALL exist from ex_ready to in_ready.
REQ-011 ex_valid SHALL be 1 exactly in HALF and FULL. The output bundle SHALL stay stable while ex_valid && !ex_ready.
REQ-012 Ordering SHALL be strictly first-in first-out, and no entry SHALL be duplicated or dropped, except by flush.
REQ-013 flush=1 SHALL force the state to EMPTY on the next edge and SHALL discard any same-cycle input. ex_valid SHALL be 0 in the following cycle. flush SHALL take priority over all simultaneous transfers.

Reset
REQ-014 While rst=1, the block SHALL be in state EMPTY with these output values: ex_valid=0, in_ready=0, alu_a=0, alu_b=0, alu_op=ALU_ADD, rd=0, reg_write=0, illegal=0.
REQ-015 in_ready SHALL rise on the first clock edge after rst is deasserted. Assertion of rst mid-operation SHALL discard all held entries immediately, without waiting for a clock edge.

Verification
REQ-016 ADD: instr=0x002081B3, rs1_data=5, rs2_data=7, ex_ready=1 -> the next cycle shows ex_valid=1, ALU_ADD, a=5, b=7, rd=3, reg_write=1.
REQ-017 Immediates: instr=0xFFF00093 (ADDI x1,x0,-1) -> b=0xFFFFFFFF, ALU_ADD. instr=0x00309293 (SLLI x5,x1,3) -> ALU_SLLI, b=3, rd=5.
REQ-018 Backpressure: hold ex_ready=0 and offer three back-to-back instructions -> two are accepted and in_ready=0. Then set ex_ready=1 -> the instructions drain in order with no gap, and the third is accepted after in_ready returns to 1.
REQ-019 Illegal and x0 cases: instr=0x00000073 -> illegal=1, reg_write=0. A legal ADD to rd=0 -> reg_write=0, illegal=0.
REQ-020 Flush: flush=1 in state FULL with in_valid=1 -> the next cycle shows ex_valid=0 and state EMPTY, and the offered instruction never appears at the outputs.
REQ-021 Reset: assert rst asynchronously in FULL -> ex_valid=0 and in_ready=0 immediately. After rst is released, in_ready=1 on the next edge.

Source files
------------

// File: rtl/alu_issue.sv
// ALU issue stage: decodes RV32 ADD/SUB/SLT/ADDI/SLTI/SLLI into an operand bundle, 1-cycle latency.
// Main + skid register pair; in_ready is registered (state != FULL), so ex_ready never reaches it combinationally.
package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLLI = 4'd3
  } alu_op_e;
endpackage

module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_op_e     op;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_e;

  state_e      state, state_nxt;
  bundle_t     dec, main_q, skid_q;
  logic        in_fire, out_fire;
  logic        load_main, load_skid, skid_to_main;
  logic        legal;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic        unused_rs1_field;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  // Register indices are resolved upstream; only rs1_data/rs2_data matter here.
  assign unused_rs1_field = ^instr[19:15];

  always_comb begin
    dec    = '0;
    dec.op = ALU_ADD;
    dec.rd = instr[11:7];
    legal  = 1'b1;
    if (opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0000000) begin
      dec.op = ALU_ADD;
      dec.b  = rs2_data;
    end else if (opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0100000) begin
      dec.op = ALU_SUB;
      dec.b  = rs2_data;
    end else if (opcode == 7'b0110011 && funct3 == 3'b010 && funct7 == 7'b0000000) begin
      dec.op = ALU_SLT;
      dec.b  = rs2_data;
    end else if (opcode == 7'b0010011 && funct3 == 3'b000) begin
      dec.op = ALU_ADD;
      dec.b  = imm_i;
    end else if (opcode == 7'b0010011 && funct3 == 3'b010) begin
      dec.op = ALU_SLT;
      dec.b  = imm_i;
    end else if (opcode == 7'b0010011 && funct3 == 3'b001 && funct7 == 7'b0000000) begin
      dec.op = ALU_SLLI;
      dec.b  = {27'b0, instr[24:20]};
    end else begin
      legal = 1'b0;
    end

    if (legal) begin
      dec.a         = rs1_data;
      dec.reg_write = |instr[11:7];
    end else begin
      dec.illegal = 1'b1;
    end
  end

  assign ex_valid = (state != EMPTY);
  assign in_fire  = in_valid && in_ready && !flush;
  assign out_fire = ex_valid && ex_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          state_nxt = HALF;
          load_main = 1'b1;
        end
        HALF: begin
          if (in_fire && !out_fire) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (out_fire && !in_fire) begin
            state_nxt = EMPTY;
          end else if (in_fire && out_fire) begin
            load_main = 1'b1;
          end
        end
        FULL: if (out_fire) begin
          state_nxt    = HALF;
          skid_to_main = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= dec;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign alu_a     = main_q.a;
  assign alu_b     = main_q.b;
  assign alu_op    = main_q.op;
  assign rd        = main_q.rd;
  assign reg_write = main_q.reg_write;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a scoreboard queue of hand-computed expected bundles.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        in_ready, ex_valid, reg_write, illegal;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  rd;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .rd(rd),
    .reg_write(reg_write), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t cur_exp;
  int   total = 0;
  int   bad = 0;
  int   out_count = 0;
  logic last_in_fire = 1'b0;

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                              input logic [4:0] r, input logic we, input logic ill);
    mk = {a, b, op, r, we, ill};
  endfunction

  function automatic exp_t observed();
    observed = {alu_a, alu_b, alu_op, rd, reg_write, illegal};
  endfunction

  task automatic chk(input string tag, input logic [74:0] got, input logic [74:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, expv);
    end
  endtask

  // Called at a falling edge: score outputs, record transfers, advance one cycle.
  task automatic tick();
    logic inf, outf;
    inf  = in_valid && in_ready && !flush;
    outf = ex_valid && ex_ready;
    if (ex_valid) begin
      chk("sb_has_entry", 75'(q.size() != 0), 75'd1);
      if (q.size() != 0) begin
        chk("sb_bundle", observed(), q[0]);
        if (outf) begin
          void'(q.pop_front());
          out_count++;
        end
      end
    end
    if (flush) q.delete();
    if (inf) q.push_back(cur_exp);
    last_in_fire = inf;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                        input exp_t e);
    instr    = i;
    rs1_data = r1;
    rs2_data = r2;
    cur_exp  = e;
    in_valid = 1'b1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                       input exp_t e);
    set_in(i, r1, r2, e);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (last_in_fire) break;
    end
    chk("accept", 75'(last_in_fire), 75'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drained", 75'(q.size() == 0), 75'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ex_valid", 75'(ex_valid), 75'd0);
    chk("rst_in_ready", 75'(in_ready), 75'd0);
    chk("rst_bundle", observed(), mk(0, 0, ALU_ADD, 0, 0, 0));
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rst", 75'(in_ready), 75'd1);

    // Single ADD with one-cycle latency
    ex_ready = 1'b1;
    set_in(32'h002081B3, 32'd5, 32'd7, mk(5, 7, ALU_ADD, 3, 1, 0));
    tick();
    in_valid = 1'b0;
    chk("add_accepted", 75'(last_in_fire), 75'd1);
    chk("add_latency", 75'(ex_valid), 75'd1);
    chk("add_bundle", observed(), mk(5, 7, ALU_ADD, 3, 1, 0));
    drain();

    // Streamed decode patterns, back-to-back
    offer(32'hFFF00093, 32'd0, 32'd0, mk(0, 32'hFFFFFFFF, ALU_ADD, 1, 1, 0));
    offer(32'h00309293, 32'h0000000A, 32'd0, mk(32'h0A, 3, ALU_SLLI, 5, 1, 0));
    offer(32'h40208233, 32'd9, 32'd4, mk(9, 4, ALU_SUB, 4, 1, 0));
    offer(32'h0020A333, 32'd3, 32'd8, mk(3, 8, ALU_SLT, 6, 1, 0));
    offer(32'h8000A393, 32'h11, 32'd0, mk(32'h11, 32'hFFFFF800, ALU_SLT, 7, 1, 0));
    offer(32'h00000073, 32'h55, 32'h66, mk(0, 0, ALU_ADD, 0, 0, 1));
    offer(32'h40309293, 32'h55, 32'h66, mk(0, 0, ALU_ADD, 5, 0, 1));
    offer(32'h022081B3, 32'h55, 32'h66, mk(0, 0, ALU_ADD, 3, 0, 1));
    offer(32'h00208033, 32'd5, 32'd7, mk(5, 7, ALU_ADD, 0, 0, 0));
    drain();

    // Backpressure: two accepted, third waits
    ex_ready = 1'b0;
    offer(32'h002081B3, 32'd1, 32'd2, mk(1, 2, ALU_ADD, 3, 1, 0));
    offer(32'h40208233, 32'd3, 32'd4, mk(3, 4, ALU_SUB, 4, 1, 0));
    set_in(32'h0020A333, 32'd5, 32'd6, mk(5, 6, ALU_SLT, 6, 1, 0));
    tick();
    chk("bp_third_refused", 75'(last_in_fire), 75'd0);
    chk("bp_in_ready_low", 75'(in_ready), 75'd0);
    tick();
    chk("bp_still_low", 75'(in_ready), 75'd0);
    ex_ready = 1'b1;
    out_count = 0;
    tick();
    tick();
    chk("bp_third_accepted", 75'(last_in_fire), 75'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_no_gap", 75'(out_count), 75'd3);
    chk("bp_empty", 75'(q.size() == 0), 75'd1);

    // Flush in FULL with a same-cycle offer
    ex_ready = 1'b0;
    offer(32'h002081B3, 32'd10, 32'd20, mk(10, 20, ALU_ADD, 3, 1, 0));
    offer(32'h002081B3, 32'd30, 32'd40, mk(30, 40, ALU_ADD, 3, 1, 0));
    chk("fl_full", 75'(in_ready), 75'd0);
    set_in(32'h00309293, 32'd1, 32'd0, mk(1, 3, ALU_SLLI, 5, 1, 0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_ex_valid", 75'(ex_valid), 75'd0);
    chk("fl_in_ready", 75'(in_ready), 75'd1);
    ex_ready = 1'b1;
    repeat (3) tick();
    chk("fl_nothing_out", 75'(ex_valid), 75'd0);

    // Asynchronous reset while FULL
    ex_ready = 1'b0;
    offer(32'h002081B3, 32'd1, 32'd1, mk(1, 1, ALU_ADD, 3, 1, 0));
    offer(32'h002081B3, 32'd2, 32'd2, mk(2, 2, ALU_ADD, 3, 1, 0));
    #2 rst = 1'b1;
    #1;
    chk("arst_ex_valid", 75'(ex_valid), 75'd0);
    chk("arst_in_ready", 75'(in_ready), 75'd0);
    chk("arst_bundle", observed(), mk(0, 0, ALU_ADD, 0, 0, 0));
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("arst_ready_before_edge", 75'(in_ready), 75'd0);
    @(posedge clk);
    @(negedge clk);
    chk("arst_ready_after_edge", 75'(in_ready), 75'd1);
    ex_ready = 1'b1;
    offer(32'h002081B3, 32'd8, 32'd9, mk(8, 9, ALU_ADD, 3, 1, 0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
